wb_test_mbox: RTL and testbench
===============================

# wb_test_mbox

Wishbone B4 classic responder that firmware running on the management SoC or the user RISC-V core writes to, to report test progress. It replaces the ad-hoc GPIO checkbit handshake with an on-chip status mailbox. It drives a 16-bit checkbits word (routed to mprj_io[31:16] by the pinmux) and runs a start/pass/timeout monitor. It also buffers free-form debug words in a small FIFO. It sits on the user Wishbone interconnect behind wb_host as a slave.

## Interface
Parameters:
- FIFO_DEPTH, 8, debug FIFO entries (power of two, 2..16)
- TIMEOUT_W, 16, width of the timeout counter/limit

Ports:
- wb_clk_i  in  1  Wishbone clock; sole clock
- wb_rst_i  in  1  asynchronous, active-high reset
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  4  word index (byte address bits [5:2])
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables
- wb_dat_o  out  32  read data, valid with ack
- wb_ack_o  out  1  transfer acknowledge
- wb_err_o  out  1  error acknowledge for unmapped index
- checkbits_o  out  16  registered CHECK[15:0]
- pass_o  out  1  monitor in PASS
- fail_o  out  1  monitor in FAIL
- irq_o  out  1  level interrupt: irq_en & (pass | fail | overflow)

## Operation
- Register map:
  - 0 CHECK RW: [15:0] checkbits, byte-enable honoured.
  - 1 CTRL RW: [0] mon_en, [1] irq_en; [2] clr is write-1 self-clearing and reads 0.
  - 2 STATUS RO: [0] started, [1] pass, [2] fail, [3] fifo_empty, [4] fifo_full, [5] overflow (sticky), [12:8] fifo level.
  - 3 FIFO: write pushes wb_dat_i; read pops the head.
  - 4 CODES RW: [15:0] start code (reset 0xAB60), [31:16] pass code (reset 0xAB6A).
  - 5 TIMEOUT RW: [TIMEOUT_W-1:0] cycle limit; 0 disables.
  - Index 6..15: wb_err_o instead of ack, no side effect, wb_dat_o = 0.
- The byte-enable rule applies to CHECK, CTRL, CODES and TIMEOUT. The FIFO push ignores wb_sel_i and stores all 32 bits.
- Monitor FSM states and transitions:
  - IDLE -> STARTED when mon_en and checkbits_o == start code; the timeout counter clears to 0 on entry.
  - STARTED -> PASS when checkbits_o == pass code.
  - STARTED -> FAIL when the limit is nonzero and the counter == limit.
  - In STARTED the counter increments each cycle and saturates.
  - PASS and FAIL hold until clr. clr returns the FSM to IDLE, empties the FIFO and clears overflow.
  - Clearing mon_en in STARTED returns the FSM to IDLE; it has no effect in PASS or FAIL.
- FIFO behaviour:
  - Push when full: data is dropped and overflow is set.
  - Read when empty: returns 0, no pop, no error.
  - Level is 0..FIFO_DEPTH; FIFO pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - All outputs 0.
  - CHECK 0, CTRL 0, TIMEOUT 0; CODES at the values above.
  - FIFO empty, FSM in IDLE.

## Timing
- ack/err asserts exactly one cycle after the first cycle with cyc & stb, and lasts one cycle.
- No new transfer is accepted in the ack cycle. Back-to-back transfers therefore yield ack every second cycle.
- A transfer is never acknowledged twice.
- Writes take effect on the ack edge. checkbits_o updates in the same edge as ack.
- The FSM evaluates the registered checkbits_o, so a match is seen one cycle after the write's ack. pass_o/fail_o are registered and assert on the following edge.
- Read data is captured at request. A FIFO read pops on the ack edge.
- Simultaneous events:
  - Pass code match and timeout in the same cycle: PASS wins.
  - clr together with a FIFO push in the same write is impossible (different indices).
  - clr in the same cycle as a monitor transition: clr wins.
- Dropping cyc before ack aborts the transfer: no ack, no side effect.
- Asynchronous reset mid-transfer drops ack immediately and discards the transfer.

## Structure
- Shared package holds:
  - register index constants
  - CTRL/STATUS bit positions
  - reset values of the start and pass codes
  - FSM state encoding (IDLE, STARTED, PASS, FAIL)
- One sub-module: wb_test_mbox_fifo, a synchronous FIFO with FIFO_DEPTH and width 32, with push/pop, full/empty, level and async active-high reset.
- The register decode and the FSM live in the top module.

## Test plan
- Reset, then read all indices 0..5 -> 0, 0, 0x0000_0008, 0, 0xAB6A_AB60, 0; err on index 7, read data 0; checkbits_o = 0.
- Set CTRL=1, write CHECK 0xAB60, then write CHECK 0xAB6A -> STATUS.started then pass; pass_o = 1 two cycles after the second ack; irq_o stays 0 because irq_en is 0.
- Set TIMEOUT=100, CTRL=3, write CHECK 0xAB60 and idle -> fail_o and irq_o after 100 counted cycles; write CTRL=4 (clr) -> fail_o = 0, FSM back in IDLE.
- Push 9 words 0x1..0x9 with depth 8 -> full, overflow set; pops return 0x1..0x8, then a ninth pop returns 0 with empty = 1.
- Write CHECK with sel=4'b0010 and data 0x0000_CD00 over 0x0000_AB60 -> checkbits_o = 0xCD60.
- Assert wb_rst_i asynchronously between request and ack -> ack never seen, all registers at reset values.

Source files
------------

// File: rtl/wb_test_mbox_pkg.sv
// Shared definitions for the test-status mailbox: register map, bit positions,
// code reset values, monitor state encoding and a byte-enable merge helper.
package wb_test_mbox_pkg;

    localparam logic [3:0] REG_CHECK   = 4'd0;
    localparam logic [3:0] REG_CTRL    = 4'd1;
    localparam logic [3:0] REG_STATUS  = 4'd2;
    localparam logic [3:0] REG_FIFO    = 4'd3;
    localparam logic [3:0] REG_CODES   = 4'd4;
    localparam logic [3:0] REG_TIMEOUT = 4'd5;

    localparam int unsigned CTRL_MON_EN = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_CLR    = 2;

    localparam int unsigned STAT_STARTED   = 0;
    localparam int unsigned STAT_PASS      = 1;
    localparam int unsigned STAT_FAIL      = 2;
    localparam int unsigned STAT_EMPTY     = 3;
    localparam int unsigned STAT_FULL      = 4;
    localparam int unsigned STAT_OVF       = 5;
    localparam int unsigned STAT_LEVEL_LSB = 8;

    localparam logic [15:0] START_CODE_RST = 16'hAB60;
    localparam logic [15:0] PASS_CODE_RST  = 16'hAB6A;

    typedef enum logic [1:0] {
        MON_IDLE    = 2'd0,
        MON_STARTED = 2'd1,
        MON_PASS    = 2'd2,
        MON_FAIL    = 2'd3
    } mon_state_e;

    // Replace the bytes of old_val selected by sel with those of new_val
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_test_mbox_fifo.sv
// Synchronous debug-word FIFO; pushes when full and pops when empty are ignored.
module wb_test_mbox_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [4:0]       level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push_c;
    logic             do_pop_c;

    assign full_c    = (count == CW'(DEPTH));
    assign empty_c   = (count == '0);
    assign do_push_c = push & ~full_c;
    assign do_pop_c  = pop & ~empty_c;
    assign head_c    = mem[rd_ptr];
    assign level     = 5'(count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push_c && !do_pop_c)      count <= count + CW'(1);
            else if (do_pop_c && !do_push_c) count <= count - CW'(1);
        end
    end

    // Storage needs no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_test_mbox.sv
// Wishbone test-status mailbox: checkbits register, start/pass/timeout monitor
// and a debug FIFO, acknowledged one cycle after each request.
module wb_test_mbox
    import wb_test_mbox_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [15:0] checkbits_o,
    output logic        pass_o,
    output logic        fail_o,
    output logic        irq_o
);

    logic [15:0]          check_q;
    logic [15:0]          start_code_q;
    logic [15:0]          pass_code_q;
    logic [TIMEOUT_W-1:0] timeout_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;
    logic                 mon_en_q;
    logic                 irq_en_q;
    logic                 ovf_q;
    mon_state_e           state_q;
    mon_state_e           state_d;

    logic        req_c;
    logic        mapped_c;
    logic        wr_c;
    logic        rd_c;
    logic        clr_c;
    logic        push_c;
    logic        pop_c;
    logic [31:0] rdata_c;
    logic [31:0] status_c;
    logic [31:0] merged_c;

    logic [31:0] fifo_head_c;
    logic        fifo_full_c;
    logic        fifo_empty_c;
    logic [4:0]  fifo_level;

    // A request is blocked during its own response cycle, so each is answered once
    assign req_c    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign mapped_c = (wb_adr_i <= REG_TIMEOUT);
    assign wr_c     = req_c & mapped_c & wb_we_i;
    assign rd_c     = req_c & mapped_c & ~wb_we_i;
    assign merged_c = merge_bytes(rdata_c, wb_dat_i, wb_sel_i);
    assign clr_c    = wr_c & (wb_adr_i == REG_CTRL) & merged_c[CTRL_CLR];
    assign push_c   = wr_c & (wb_adr_i == REG_FIFO);
    assign pop_c    = rd_c & (wb_adr_i == REG_FIFO);
    assign checkbits_o = check_q;

    // Read mux; for the RW registers this is also the pre-write value
    always_comb begin
        status_c = '0;
        status_c[STAT_STARTED] = (state_q == MON_STARTED);
        status_c[STAT_PASS]    = (state_q == MON_PASS);
        status_c[STAT_FAIL]    = (state_q == MON_FAIL);
        status_c[STAT_EMPTY]   = fifo_empty_c;
        status_c[STAT_FULL]    = fifo_full_c;
        status_c[STAT_OVF]     = ovf_q;
        status_c[STAT_LEVEL_LSB +: 5] = fifo_level;

        rdata_c = '0;
        case (wb_adr_i)
            REG_CHECK:   rdata_c = {16'h0000, check_q};
            REG_CTRL: begin
                rdata_c[CTRL_MON_EN] = mon_en_q;
                rdata_c[CTRL_IRQ_EN] = irq_en_q;
            end
            REG_STATUS:  rdata_c = status_c;
            REG_FIFO:    rdata_c = fifo_empty_c ? 32'h0 : fifo_head_c;
            REG_CODES:   rdata_c = {pass_code_q, start_code_q};
            REG_TIMEOUT: rdata_c = 32'(timeout_q);
            default:     rdata_c = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            wb_dat_o     <= '0;
            check_q      <= '0;
            mon_en_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            start_code_q <= START_CODE_RST;
            pass_code_q  <= PASS_CODE_RST;
            timeout_q    <= '0;
            ovf_q        <= 1'b0;
        end else begin
            wb_ack_o <= req_c & mapped_c;
            wb_err_o <= req_c & ~mapped_c;
            wb_dat_o <= rd_c ? rdata_c : 32'h0;
            if (wr_c) begin
                case (wb_adr_i)
                    REG_CHECK: check_q <= merged_c[15:0];
                    REG_CTRL: begin
                        mon_en_q <= merged_c[CTRL_MON_EN];
                        irq_en_q <= merged_c[CTRL_IRQ_EN];
                    end
                    REG_CODES: begin
                        start_code_q <= merged_c[15:0];
                        pass_code_q  <= merged_c[31:16];
                    end
                    REG_TIMEOUT: timeout_q <= merged_c[TIMEOUT_W-1:0];
                    default: ;
                endcase
            end
            if (clr_c)                      ovf_q <= 1'b0;
            else if (push_c && fifo_full_c) ovf_q <= 1'b1;
        end
    end

    // Monitor next state; clr overrides any transition in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MON_IDLE: begin
                if (mon_en_q && (check_q == start_code_q)) begin
                    state_d = MON_STARTED;
                    cnt_d   = '0;
                end
            end
            MON_STARTED: begin
                if (cnt_q != '1) cnt_d = cnt_q + TIMEOUT_W'(1);
                if (!mon_en_q)                                       state_d = MON_IDLE;
                else if (check_q == pass_code_q)                     state_d = MON_PASS;
                else if ((timeout_q != '0) && (cnt_q == timeout_q))  state_d = MON_FAIL;
            end
            default: ;
        endcase
        if (clr_c) state_d = MON_IDLE;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= MON_IDLE;
            cnt_q   <= '0;
            pass_o  <= 1'b0;
            fail_o  <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_o  <= (state_q == MON_PASS);
            fail_o  <= (state_q == MON_FAIL);
            irq_o   <= irq_en_q & ((state_q == MON_PASS) | (state_q == MON_FAIL) | ovf_q);
        end
    end

    wb_test_mbox_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (clr_c),
        .push   (push_c),
        .pop    (pop_c),
        .din    (wb_dat_i),
        .head_c (fifo_head_c),
        .full_c (fifo_full_c),
        .empty_c(fifo_empty_c),
        .level  (fifo_level)
    );

endmodule

// File: tb/tb_wb_test_mbox.sv
// Scoreboard bench for wb_test_mbox: a transaction-level mailbox model predicts
// every response; a negedge monitor pops and compares each ack/err.
module tb_wb_test_mbox;

    localparam int DEPTH = 8;
    localparam int S_IDLE = 0, S_STARTED = 1, S_PASS = 2, S_FAIL = 3;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [15:0] checkbits_o;
    logic        pass_o, fail_o, irq_o;

    wb_test_mbox #(.FIFO_DEPTH(DEPTH), .TIMEOUT_W(16)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .checkbits_o(checkbits_o),
        .pass_o     (pass_o),
        .fail_o     (fail_o),
        .irq_o      (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
        logic [3:0]  idx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model of the mailbox at register/transaction level
    logic [15:0] m_check, m_start, m_pass, m_timeout;
    logic        m_mon_en, m_irq_en, m_ovf;
    int          m_mon;
    logic [31:0] m_fifo[$];

    task automatic model_reset();
        m_check = 16'h0; m_start = 16'hAB60; m_pass = 16'hAB6A; m_timeout = 16'h0;
        m_mon_en = 1'b0; m_irq_en = 1'b0; m_ovf = 1'b0; m_mon = S_IDLE;
        m_fifo.delete();
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_value(input logic [3:0] adr);
        logic [31:0] v;
        v = 32'h0;
        case (adr)
            4'd0: v = {16'h0, m_check};
            4'd1: v = {30'h0, m_irq_en, m_mon_en};
            4'd2: begin
                v[0] = (m_mon == S_STARTED);
                v[1] = (m_mon == S_PASS);
                v[2] = (m_mon == S_FAIL);
                v[3] = (m_fifo.size() == 0);
                v[4] = (m_fifo.size() == DEPTH);
                v[5] = m_ovf;
                v[12:8] = 5'(m_fifo.size());
            end
            4'd3: v = (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
            4'd4: v = {m_pass, m_start};
            4'd5: v = {16'h0, m_timeout};
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Given a few quiet cycles, the monitor reaches wherever its rules lead
    task automatic model_settle();
        for (int k = 0; k < 3; k++) begin
            if (m_mon == S_IDLE && m_mon_en && m_check == m_start) m_mon = S_STARTED;
            else if (m_mon == S_STARTED && !m_mon_en)              m_mon = S_IDLE;
            else if (m_mon == S_STARTED && m_check == m_pass)      m_mon = S_PASS;
        end
    endtask

    task automatic model_access(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, output exp_t e);
        logic [31:0] cur, nv;
        e.err = (adr > 4'd5); e.chk = !we || e.err; e.data = 32'h0; e.idx = adr;
        if (e.err) return;
        cur = model_value(adr);
        if (!we) begin
            e.data = cur;
            if (adr == 4'd3 && m_fifo.size() > 0) void'(m_fifo.pop_front());
        end else begin
            nv = merge(cur, dat, sel);
            case (adr)
                4'd0: m_check = nv[15:0];
                4'd1: begin
                    m_mon_en = nv[0]; m_irq_en = nv[1];
                    if (nv[2]) begin m_mon = S_IDLE; m_fifo.delete(); m_ovf = 1'b0; end
                end
                4'd3: if (m_fifo.size() < DEPTH) m_fifo.push_back(dat); else m_ovf = 1'b1;
                4'd4: begin m_start = nv[15:0]; m_pass = nv[31:16]; end
                4'd5: m_timeout = nv[15:0];
                default: ;
            endcase
            model_settle();
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_out(input string tag);
        cmp({tag, ".checkbits"}, 32'(checkbits_o), 32'(m_check));
        cmp({tag, ".pass"}, 32'(pass_o), 32'(m_mon == S_PASS));
        cmp({tag, ".fail"}, 32'(fail_o), 32'(m_mon == S_FAIL));
        cmp({tag, ".irq"}, 32'(irq_o),
            32'(m_irq_en & ((m_mon == S_PASS) | (m_mon == S_FAIL) | m_ovf)));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    // One transfer; returns one ns after the response edge
    task automatic bus(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
        exp_t e;
        bit   got;
        model_access(we, adr, dat, sel, e);
        sb.push_back(e);
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wb_ack_o || wb_err_o) begin got = 1'b1; break; end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bus_response idx=%0d actual=none required=ack/err within 4 cycles", adr);
        end
    endtask

    task automatic xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
        bus(we, adr, dat, sel);
        idle(3);
    endtask

    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && (wb_ack_o || wb_err_o)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_response actual=ack%0b/err%0b required=none", wb_ack_o, wb_err_o);
            end else begin
                mon_e = sb.pop_front();
                if (wb_err_o !== mon_e.err || wb_ack_o !== ~mon_e.err ||
                    (mon_e.chk && wb_dat_o !== mon_e.data)) begin
                    errors++;
                    $display("FAIL bus_resp idx=%0d actual ack=%0b err=%0b dat=%h required err=%0b dat=%h",
                             mon_e.idx, wb_ack_o, wb_err_o, wb_dat_o, mon_e.err, mon_e.data);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [15:0] v;
        logic [3:0]  sel;
        int          r;

        wb_rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 4'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0;
        model_reset();
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        idle(1);

        // Reset state and unmapped index
        check_out("reset");
        for (int a = 0; a < 6; a++) xfer(1'b0, 4'(a), 32'h0, 4'hF);
        xfer(1'b0, 4'd7, 32'h0, 4'hF);

        // Randomised register/FIFO/monitor traffic
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            case (r)
                0, 1: xfer(1'b1, 4'd3, $urandom, 4'($urandom_range(0, 15)));
                2, 3: xfer(1'b0, 4'd3, 32'h0, 4'hF);
                4: begin
                    r = $urandom_range(0, 3);
                    v = (r == 0) ? m_start : (r == 1) ? m_pass : 16'($urandom);
                    xfer(1'b1, 4'd0, {16'($urandom), v}, sel);
                end
                5: begin
                    d = 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 5) == 0) d = d | 32'h4;
                    xfer(1'b1, 4'd1, d | (32'($urandom) & 32'hFFFF_FF00), sel);
                end
                6: xfer(1'b0, 4'($urandom_range(0, 15)), 32'h0, 4'hF);
                7: xfer(1'b1, ($urandom_range(0, 1) == 0) ? 4'd2 : 4'($urandom_range(6, 15)),
                        $urandom, 4'hF);
                8: xfer(1'b0, 4'd2, 32'h0, 4'hF);
                default: xfer(1'b0, 4'($urandom_range(0, 1)) * 4'd4, 32'h0, 4'hF);
            endcase
            check_out("rand");
        end

        // Start then pass, no interrupt
        xfer(1'b1, 4'd1, 32'h4, 4'hF);
        xfer(1'b1, 4'd0, 32'h0, 4'hF);
        xfer(1'b1, 4'd1, 32'h1, 4'hF);
        xfer(1'b1, 4'd0, 32'h0000_AB60, 4'hF);
        xfer(1'b0, 4'd2, 32'h0, 4'hF);
        bus(1'b1, 4'd0, 32'h0000_AB6A, 4'hF);
        idle(1);
        cmp("pass_ack_plus1", 32'(pass_o), 32'h0);
        idle(1);
        cmp("pass_ack_plus2", 32'(pass_o), 32'h1);
        cmp("pass_irq_off", 32'(irq_o), 32'h0);
        idle(2);
        check_out("pass");
        xfer(1'b0, 4'd2, 32'h0, 4'hF);

        // Timeout to FAIL, then clr
        xfer(1'b1, 4'd1, 32'h4, 4'hF);
        xfer(1'b1, 4'd5, 32'd100, 4'hF);
        xfer(1'b1, 4'd1, 32'h3, 4'hF);
        bus(1'b1, 4'd0, 32'h0000_AB60, 4'hF);
        idle(102);
        cmp("fail_ack_plus102", 32'(fail_o), 32'h0);
        idle(1);
        cmp("fail_ack_plus103", 32'(fail_o), 32'h1);
        cmp("fail_irq", 32'(irq_o), 32'h1);
        m_mon = S_FAIL;
        idle(2);
        xfer(1'b0, 4'd2, 32'h0, 4'hF);
        xfer(1'b1, 4'd1, 32'h4, 4'hF);
        check_out("clr");
        xfer(1'b0, 4'd2, 32'h0, 4'hF);
        xfer(1'b1, 4'd5, 32'h0, 4'hF);

        // FIFO overflow and drain past empty
        for (int i = 1; i <= 9; i++) xfer(1'b1, 4'd3, 32'(i), 4'h1);
        xfer(1'b0, 4'd2, 32'h0, 4'hF);
        cmp("fifo_ovf_model", 32'(m_ovf), 32'h1);
        for (int i = 0; i < 9; i++) xfer(1'b0, 4'd3, 32'h0, 4'hF);
        xfer(1'b0, 4'd2, 32'h0, 4'hF);
        xfer(1'b1, 4'd1, 32'h4, 4'hF);

        // Byte-enable on CHECK
        xfer(1'b1, 4'd0, 32'h0000_AB60, 4'hF);
        xfer(1'b1, 4'd0, 32'h0000_CD00, 4'b0010);
        cmp("sel_checkbits", 32'(checkbits_o), 32'h0000_CD60);
        check_out("sel");

        // Held strobe: one response every second cycle
        sb.push_back('{err: 1'b0, chk: 1'b1, data: {16'h0, m_check}, idx: 4'd0});
        sb.push_back('{err: 1'b0, chk: 1'b1, data: {16'h0, m_check}, idx: 4'd0});
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'd0; wb_sel_i = 4'hF;
        idle(4);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        idle(3);
        cmp("b2b_drained", 32'(sb.size()), 32'h0);

        // Request withdrawn before the clock edge
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 4'd0;
        wb_dat_i = 32'h0000_1234; wb_sel_i = 4'hF;
        #2;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        idle(3);
        check_out("abort");

        // Reset asserted during the request cycle
        xfer(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF);
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 4'd0;
        wb_dat_i = 32'h0000_5555; wb_sel_i = 4'hF;
        #2;
        wb_rst_i = 1'b1;
        #1;
        cmp("rst_req_ack", 32'(wb_ack_o), 32'h0);
        idle(1);
        cmp("rst_req_ack_edge", 32'({wb_ack_o, wb_err_o}), 32'h0);
        @(negedge wb_clk_i);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_rst_i = 1'b0;
        model_reset();
        idle(2);
        check_out("rst1");
        for (int a = 0; a < 6; a++) xfer(1'b0, 4'(a), 32'h0, 4'hF);

        // Reset asserted while ack is high
        xfer(1'b1, 4'd0, 32'h0000_1234, 4'hF);
        xfer(1'b1, 4'd3, 32'h0000_0042, 4'hF);
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 4'd0;
        wb_dat_i = 32'h0000_7777; wb_sel_i = 4'hF;
        idle(1);
        cmp("rst_ack_before", 32'(wb_ack_o), 32'h1);
        #1;
        wb_rst_i = 1'b1;
        #1;
        cmp("rst_ack_dropped", 32'(wb_ack_o), 32'h0);
        @(negedge wb_clk_i);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_rst_i = 1'b0;
        model_reset();
        idle(2);
        check_out("rst2");
        for (int a = 0; a < 6; a++) xfer(1'b0, 4'(a), 32'h0, 4'hF);

        idle(4);
        cmp("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
